// File: rtl/psone_poll_sched.sv
// psone_poll_sched: paces PS1 pad packet polls, collects the 9 reply bytes,
// retries bad/late packets and streams accepted frames to psone_uart.
module psone_poll_sched #(
   parameter int unsigned POLL_PERIOD    = 833_333,
   parameter int unsigned TIMEOUT        = 200_000,
   parameter int unsigned MAX_RETRY      = 3,
   parameter bit          SEND_ON_CHANGE = 1'b1
) (
   input  logic       iCLK,
   input  logic       iRESET,
   input  logic       iEN,
   output logic       oPOLL_ST,
   input  logic       iPOLL_DONE,
   input  logic       iPOLL_ERR,
   input  logic       iRX_VALID,
   input  logic [7:0] iRX_BYTE,
   output logic       oTRAN_ST,
   output logic [7:0] oTX_BYTE,
   input  logic       iTRAN_BUSY,
   output logic       oFAULT,
   output logic [7:0] oFRAME_CNT
);

   localparam int unsigned PER_W = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;
   localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam int unsigned RT_W  = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [PER_W-1:0] PER_RELOAD = PER_W'(POLL_PERIOD - 1);
   localparam logic [TO_W-1:0]  TO_LIMIT   = TO_W'(TIMEOUT);
   localparam logic [RT_W-1:0]  RT_LIMIT   = RT_W'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_IDLE,
      S_POLL,
      S_CHECK,
      S_SEND,
      S_TX_WAIT,
      S_GAP
   } state_t;

   state_t            state_q, state_d;
   logic              en_q;
   logic [PER_W-1:0]  per_cnt_q;
   logic [TO_W-1:0]   to_cnt_q;
   logic [RT_W-1:0]   retry_q;
   logic [3:0]        idx_q;
   logic [1:0]        wait_q;
   logic [8:0][7:0]   buf_q;
   logic [8:0][7:0]   last_q;

   logic en_rise, per_exp, to_hit, rx_full, frame_eq, busy_ok, last_byte;
   logic poll_st_d, tran_st_d;
   logic per_reload, per_force, to_clr, to_inc, rx_wr, idx_clr, idx_inc;
   logic retry_inc, retry_clr, fault_set, last_copy, tx_load, frame_inc;

   // Condition decode shared by the FSM and the datapath.
   // The period counter saturates at zero; an iEN rising edge also counts as
   // expired so the first poll goes out without waiting a full period.
   always_comb begin
      en_rise   = iEN & ~en_q;
      per_exp   = (per_cnt_q == '0) | en_rise;
      to_hit    = (to_cnt_q == TO_LIMIT);
      rx_full   = (idx_q == 4'd9);
      frame_eq  = (buf_q == last_q);
      busy_ok   = (wait_q == 2'd2) & ~iTRAN_BUSY;
      last_byte = (idx_q == 4'd8);
   end

   // State register.
   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Next-state and control decode; all pulses are registered downstream.
   always_comb begin
      state_d    = state_q;
      poll_st_d  = 1'b0;
      tran_st_d  = 1'b0;
      per_reload = 1'b0;
      per_force  = 1'b0;
      to_clr     = 1'b0;
      to_inc     = 1'b0;
      rx_wr      = 1'b0;
      idx_clr    = 1'b0;
      idx_inc    = 1'b0;
      retry_inc  = 1'b0;
      retry_clr  = 1'b0;
      fault_set  = 1'b0;
      last_copy  = 1'b0;
      tx_load    = 1'b0;
      frame_inc  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (iEN && per_exp) begin
               state_d    = S_POLL;
               poll_st_d  = 1'b1;
               per_reload = 1'b1;
               idx_clr    = 1'b1;
               to_clr     = 1'b1;
            end
         end
         S_POLL: begin
            to_inc = 1'b1;
            rx_wr  = iRX_VALID & (idx_q < 4'd9);
            if (!iEN) begin
               state_d = S_IDLE;
            end else if (iPOLL_DONE && !iPOLL_ERR && rx_full) begin
               state_d = S_CHECK;
            end else if (iPOLL_ERR || iPOLL_DONE || to_hit) begin
               // done/err is tested first, so it wins over a coincident timeout
               state_d = S_IDLE;
               if (retry_q < RT_LIMIT) begin
                  retry_inc = 1'b1;
                  per_force = 1'b1;
               end else begin
                  fault_set = 1'b1;
                  retry_clr = 1'b1;
               end
            end
         end
         S_CHECK: begin
            retry_clr = 1'b1;
            if (!iEN) begin
               state_d = S_IDLE;
            end else if (SEND_ON_CHANGE && frame_eq) begin
               state_d = S_IDLE;
            end else begin
               last_copy = 1'b1;
               idx_clr   = 1'b1;
               state_d   = S_SEND;
            end
         end
         S_SEND: begin
            if (!iEN) begin
               state_d = S_IDLE;
            end else begin
               tran_st_d = 1'b1;
               tx_load   = 1'b1;
               state_d   = S_TX_WAIT;
            end
         end
         S_TX_WAIT: begin
            if (busy_ok) begin
               if (!iEN) begin
                  state_d = S_IDLE;
               end else if (last_byte) begin
                  frame_inc = 1'b1;
                  state_d   = S_IDLE;
               end else begin
                  idx_inc = 1'b1;
                  state_d = S_GAP;
               end
            end
         end
         S_GAP: begin
            state_d = iEN ? S_SEND : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Enable edge detector.
   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) en_q <= 1'b0;
      else         en_q <= iEN;
   end

   // Poll period down-counter: reload on poll issue, forced to expired for a
   // retry or an enable edge, otherwise counts down to zero while enabled.
   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET)                      per_cnt_q <= '0;
      else if (per_reload)              per_cnt_q <= PER_RELOAD;
      else if (per_force || en_rise)    per_cnt_q <= '0;
      else if (iEN && per_cnt_q != '0)  per_cnt_q <= per_cnt_q - PER_W'(1);
   end

   // Packet timeout counter, counting POLL cycles since the poll pulse.
   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET)                          to_cnt_q <= '0;
      else if (to_clr)                      to_cnt_q <= '0;
      else if (to_inc && !to_hit)           to_cnt_q <= to_cnt_q + TO_W'(1);
   end

   // Byte index, shared by capture (POLL) and transmit (SEND/TX_WAIT).
   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET)                 idx_q <= '0;
      else if (idx_clr)            idx_q <= '0;
      else if (rx_wr || idx_inc)   idx_q <= idx_q + 4'd1;
   end

   // Capture buffer.
   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET)    buf_q <= '0;
      else if (rx_wr) buf_q[idx_q] <= iRX_BYTE;
   end

   // Last transmitted frame; all-ones at reset so the first frame differs.
   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET)        last_q <= '1;
      else if (last_copy) last_q <= buf_q;
   end

   // Retry counter and sticky fault, both cleared by an enable rising edge.
   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         retry_q <= '0;
         oFAULT  <= 1'b0;
      end else begin
         if (en_rise || retry_clr) retry_q <= '0;
         else if (retry_inc)       retry_q <= retry_q + RT_W'(1);
         if (en_rise)              oFAULT  <= 1'b0;
         else if (fault_set)       oFAULT  <= 1'b1;
      end
   end

   // Busy-ignore window: TX_WAIT disregards iTRAN_BUSY for its first 2 cycles.
   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET)                                    wait_q <= '0;
      else if (tx_load)                               wait_q <= '0;
      else if (state_q == S_TX_WAIT && wait_q != 2'd2) wait_q <= wait_q + 2'd1;
   end

   // Registered outputs.
   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         oPOLL_ST   <= 1'b0;
         oTRAN_ST   <= 1'b0;
         oTX_BYTE   <= '0;
         oFRAME_CNT <= '0;
      end else begin
         oPOLL_ST <= poll_st_d;
         oTRAN_ST <= tran_st_d;
         if (tx_load)   oTX_BYTE   <= buf_q[idx_q];
         if (frame_inc) oFRAME_CNT <= oFRAME_CNT + 8'd1;
      end
   end

endmodule

// File: doc/psone_poll_sched.md
# psone_poll_sched

Poll scheduler for the PS1 pad link. It issues packet-start pulses to the SPI pad transaction engine at a fixed period and buffers the 9 captured bytes. It retries failed or timed-out packets, then feeds each accepted frame byte-by-byte to the UART transmitter. Optionally it suppresses frames identical to the last one sent. It sits between the start/stop key toggle, the pad engine and `psone_uart`.

## Interface
- `POLL_PERIOD`, default 833_333: cycles from one `oPOLL_ST` to the next (60 Hz at 50 MHz).
- `TIMEOUT`, default 200_000: cycles allowed from `oPOLL_ST` to `iPOLL_DONE`.
- `MAX_RETRY`, default 3: retries after the first attempt before a frame is dropped.
- `SEND_ON_CHANGE`, default 1: when 1, a frame equal to the last sent frame is not transmitted.
- `iCLK` in 1: single system clock, rising edge.
- `iRESET` in 1: asynchronous, active-low reset.
- `iEN` in 1: polling enable (level, from key toggle).
- `oPOLL_ST` out 1: one-cycle pulse; engine starts one packet.
- `iPOLL_DONE` in 1: one-cycle pulse; engine finished packet.
- `iPOLL_ERR` in 1: one-cycle pulse, coincident with or instead of done; packet invalid.
- `iRX_VALID` in 1: one-cycle strobe; `iRX_BYTE` holds the next captured byte.
- `iRX_BYTE` in 8: captured byte, in packet order.
- `oTRAN_ST` out 1: one-cycle pulse to UART start.
- `oTX_BYTE` out 8: byte to transmit; stable from `oTRAN_ST` until the UART finishes.
- `iTRAN_BUSY` in 1: UART transmitter busy.
- `oFAULT` out 1: sticky; set when a frame is dropped after retries are exhausted.
- `oFRAME_CNT` out 8: count of frames transmitted, wraps 255→0.

## Operation
- States: IDLE, POLL, CHECK, SEND, TX_WAIT, GAP.
- IDLE:
  - Leaves when `iEN`=1 and the period counter has expired.
  - On the first cycle `iEN` is seen high, the counter counts as expired, so polling starts immediately.
  - On leaving: pulse `oPOLL_ST`, reload the period counter, clear the byte index and timeout counter, go to POLL.
- Period counter:
  - Counts every cycle while `iEN`=1 and saturates at expired.
  - If expiry occurs while the block is busy, the next poll issues on the first IDLE cycle (late poll; no catch-up, no double poll).
- POLL:
  - Each `iRX_VALID` writes `iRX_BYTE` to buffer[index] and increments the index. Strobes beyond index 8 are ignored.
  - `iPOLL_DONE` with no `iPOLL_ERR` and index==9 → CHECK.
  - Any of the following is a failed attempt: `iPOLL_ERR`; `iPOLL_DONE` with index≠9; timeout counter reaching `TIMEOUT`.
  - Failed attempt with retry count < `MAX_RETRY`: increment retry count, go to IDLE with the period counter forced to expired, so the retry issues next cycle.
  - Failed attempt otherwise: set `oFAULT`, clear retry count, go to IDLE (the period counter is not forced).
- CHECK (1 cycle):
  - Clears the retry count.
  - If `SEND_ON_CHANGE`=1 and buffer equals the last-sent copy, go to IDLE.
  - Otherwise copy the buffer into the last-sent copy, clear the byte index and go to SEND.
  - The last-sent copy resets to all 0xFF, so the first frame after reset is always sent.
- SEND: drive `oTX_BYTE`=buffer[index], pulse `oTRAN_ST`, go to TX_WAIT.
- TX_WAIT:
  - `iTRAN_BUSY` is ignored for the first 2 cycles.
  - Afterwards, `iTRAN_BUSY`=0 → index+1. Go to GAP if index < 8.
  - If index==8: increment `oFRAME_CNT` and go to IDLE.
- GAP (1 cycle) → SEND.
- `iEN` falls:
  - In POLL: abort to IDLE immediately; buffer contents are discarded.
  - In SEND/TX_WAIT/GAP: the byte in flight completes, then go to IDLE. The frame is not counted.
  - `oFAULT` and the retry count clear on the `iEN` rising edge.
- Simultaneous `iPOLL_DONE` and timeout expiry in the same cycle: the done/err result wins.

## Timing
- Reset values: `oPOLL_ST`=0, `oTRAN_ST`=0, `oTX_BYTE`=0x00, `oFAULT`=0, `oFRAME_CNT`=0, state IDLE, all counters 0, last-sent copy all 0xFF.
- `iEN` rising, sampled at edge N → `oPOLL_ST` high during cycle N+1.
- `iPOLL_DONE` at edge N → CHECK at N+1 → `oTRAN_ST` for byte 0 at N+2 (if sent).
- Next-byte `oTRAN_ST`: 2 cycles after the edge where `iTRAN_BUSY`=0 is sampled (TX_WAIT→GAP→SEND).
- Retry `oPOLL_ST`: 2 cycles after the failing event.
- All outputs are registered; no combinational paths from inputs to outputs.

## Test plan
Scenarios use `POLL_PERIOD`=100, `TIMEOUT`=40, `MAX_RETRY`=2.
- Normal poll: raise `iEN`; the engine model returns 9 bytes 0xFF,0x41,0x5A,0xFF,0xFF,... then done. Required: `oTRAN_ST`×9 with `oTX_BYTE` in that order, `oFRAME_CNT`=1, next `oPOLL_ST` exactly 100 cycles after the first.
- Change suppression: repeat an identical frame → no `oTRAN_ST`, `oFRAME_CNT` stays 1. Change byte 3 to 0xFE → 9 bytes sent, `oFRAME_CNT`=2.
- Timeout/retry: the engine never sends done → `oPOLL_ST` at t, t+42, t+84. `oFAULT`=1 after the third timeout; next poll 100 cycles after the last `oPOLL_ST`.
- Error and short packet: `iPOLL_ERR` on attempt 1 and done with only 7 bytes on attempt 2, then a good packet on attempt 3. Required: frame sent, `oFAULT`=0, retry count cleared.
- Slow UART: `iTRAN_BUSY` held high for 300 cycles per byte. Required: period expiries are absorbed, exactly one `oPOLL_ST` on the first IDLE cycle after byte 8 completes.
- Abort and reset: drop `iEN` mid-TX_WAIT at byte 4 → byte 4 completes, no further `oTRAN_ST`, `oFRAME_CNT` unchanged. Assert `iRESET` mid-POLL → all outputs return to reset values asynchronously.
